// File: rtl/flash_pkg.sv
// Shared constants for the parallel NOR flash writer: command set,
// status-register bit positions and FSM state encodings.
package flash_pkg;

  // Intel/StrataFlash command codes
  localparam logic [7:0] CMD_READ_ARRAY    = 8'hFF;
  localparam logic [7:0] CMD_READ_STATUS   = 8'h70;
  localparam logic [7:0] CMD_CLEAR_STATUS  = 8'h50;
  localparam logic [7:0] CMD_PROGRAM       = 8'h40;
  localparam logic [7:0] CMD_ERASE_SETUP   = 8'h20;
  localparam logic [7:0] CMD_ERASE_CONFIRM = 8'hD0;

  // Status register bit indices
  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_VPP_ERR   = 3;
  localparam int SR_LOCK_ERR  = 1;

  // FSM states
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_SETUP    = 4'd1;
  localparam logic [3:0] ST_OPERAND  = 4'd2;
  localparam logic [3:0] ST_POLL_CMD = 4'd3;
  localparam logic [3:0] ST_TURN     = 4'd4;
  localparam logic [3:0] ST_POLL_RD  = 4'd5;
  localparam logic [3:0] ST_CHECK    = 4'd6;
  localparam logic [3:0] ST_CLR      = 4'd7;
  localparam logic [3:0] ST_RESTORE  = 4'd8;
  localparam logic [3:0] ST_DONE     = 4'd9;

  // Any of the WSM failure bits set
  function automatic logic sr_error(input logic [7:0] sr);
    return sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCK_ERR];
  endfunction

endpackage

// File: rtl/flash_we_pulse.sv
// One flash write cycle: WE low for WE_CYCLES clocks, then high for one
// clock while done is raised. Reset forces WE high asynchronously.
module flash_we_pulse #(
  parameter int WE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic we,
  output logic busy,
  output logic done
);

  localparam int CW = (WE_CYCLES < 2) ? 1 : $clog2(WE_CYCLES);

  logic [CW-1:0] cnt;
  logic          low_ph;
  logic          high_ph;

  // Low phase counts WE_CYCLES clocks, then a single high recovery clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we      <= 1'b1;
      low_ph  <= 1'b0;
      high_ph <= 1'b0;
      cnt     <= '0;
    end else if (start && !low_ph && !high_ph) begin
      we     <= 1'b0;
      low_ph <= 1'b1;
      cnt    <= '0;
    end else if (low_ph) begin
      if (cnt == CW'(WE_CYCLES - 1)) begin
        we      <= 1'b1;
        low_ph  <= 1'b0;
        high_ph <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (high_ph) begin
      high_ph <= 1'b0;
    end
  end

  assign busy = low_ph | high_ph;
  assign done = high_ph;

endmodule

// File: rtl/flash_writer.sv
// Programs one 16-bit word or erases one block in a parallel NOR flash:
// issues the command cycles, polls status until the WSM is idle, clears
// status on error and always leaves the chip in read-array mode.
module flash_writer
  import flash_pkg::*;
#(
  parameter int          WE_CYCLES  = 2,
  parameter int          OE_CYCLES  = 4,
  parameter logic [19:0] POLL_LIMIT = 20'hFFFFF
) (
  input  logic        Hclock,
  input  logic        Hreset,
  input  logic [22:0] Haddress,
  input  logic [15:0] Hwritedata,
  input  logic        Herase,
  input  logic        Hselect,
  input  logic        ready,
  output logic        CE0,
  output logic        BYTE,
  output logic        VPEN,
  output logic        RP,
  output logic        OE,
  output logic        WE,
  output logic [22:0] addr,
  inout  wire  [15:0] data,
  output logic        Hready,
  output logic        Hresponse,
  output logic [7:0]  Hstatus
);

  localparam int OCW = (OE_CYCLES < 2) ? 1 : $clog2(OE_CYCLES);

  logic [3:0]     state;
  logic [15:0]    wdata_q;
  logic           erase_q;
  logic [15:0]    dq;
  logic           dq_en;
  logic           err;
  logic [19:0]    pcnt;
  logic [OCW-1:0] ocnt;
  logic           accept, wr_state, start, pbusy, pdone;

  assign CE0  = 1'b0;
  assign BYTE = 1'b1;
  assign VPEN = 1'b1;
  assign RP   = 1'b1;

  // Bus only driven while a command/data write owns it; never while OE is low
  assign data = dq_en ? dq : 16'hzzzz;

  assign accept   = Hready && ready && Hselect && (state == ST_IDLE || state == ST_DONE);
  assign wr_state = (state == ST_SETUP) || (state == ST_OPERAND) || (state == ST_POLL_CMD) ||
                    (state == ST_CLR)   || (state == ST_RESTORE);
  // Accept kicks off the first write on the same edge; later writes start
  // once the previous pulse has fully finished
  assign start    = accept || (wr_state && !pbusy);

  flash_we_pulse #(.WE_CYCLES(WE_CYCLES)) u_we (
    .clk   (Hclock),
    .rst   (Hreset),
    .start (start),
    .we    (WE),
    .busy  (pbusy),
    .done  (pdone)
  );

  // Command sequencer, status poll and completion handshake
  always_ff @(posedge Hclock or posedge Hreset) begin
    if (Hreset) begin
      state     <= ST_IDLE;
      addr      <= '0;
      wdata_q   <= '0;
      erase_q   <= 1'b0;
      dq        <= '0;
      dq_en     <= 1'b0;
      OE        <= 1'b1;
      Hready    <= 1'b1;
      Hresponse <= 1'b0;
      Hstatus   <= '0;
      err       <= 1'b0;
      pcnt      <= '0;
      ocnt      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          Hresponse <= 1'b0;
          if (accept) begin
            addr    <= Haddress;
            wdata_q <= Hwritedata;
            erase_q <= Herase;
            dq      <= {8'h00, Herase ? CMD_ERASE_SETUP : CMD_PROGRAM};
            dq_en   <= 1'b1;
            Hready  <= 1'b0;
            err     <= 1'b0;
            pcnt    <= '0;
            state   <= ST_SETUP;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SETUP: if (pdone) begin
          dq    <= erase_q ? {8'h00, CMD_ERASE_CONFIRM} : wdata_q;
          state <= ST_OPERAND;
        end
        ST_OPERAND: if (pdone) begin
          dq    <= {8'h00, CMD_READ_STATUS};
          state <= ST_POLL_CMD;
        end
        ST_POLL_CMD: if (pdone) begin
          dq_en <= 1'b0;
          state <= ST_TURN;
        end
        // One idle clock with the bus released before the flash drives it
        ST_TURN: begin
          OE    <= 1'b0;
          ocnt  <= '0;
          state <= ST_POLL_RD;
        end
        ST_POLL_RD: begin
          if (ocnt == OCW'(OE_CYCLES - 1)) begin
            Hstatus <= data[7:0];
            OE      <= 1'b1;
            if (pcnt != '1) pcnt <= pcnt + 1'b1;
            state   <= ST_CHECK;
          end else begin
            ocnt <= ocnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (!Hstatus[SR_READY] && pcnt < POLL_LIMIT) begin
            OE    <= 1'b0;
            ocnt  <= '0;
            state <= ST_POLL_RD;
          end else if (!Hstatus[SR_READY] || sr_error(Hstatus)) begin
            err   <= 1'b1;
            dq    <= {8'h00, CMD_CLEAR_STATUS};
            dq_en <= 1'b1;
            state <= ST_CLR;
          end else begin
            dq    <= {8'h00, CMD_READ_ARRAY};
            dq_en <= 1'b1;
            state <= ST_RESTORE;
          end
        end
        ST_CLR: if (pdone) begin
          dq    <= {8'h00, CMD_READ_ARRAY};
          state <= ST_RESTORE;
        end
        ST_RESTORE: if (pdone) begin
          dq_en     <= 1'b0;
          Hready    <= 1'b1;
          Hresponse <= err;
          state     <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
